// File: rtl/alu_writeback_arbiter.sv
// Return path of the out-of-order issue interface.
// Tracks per-unit occupancy (IDLE/BUSY/DONE), captures each unit's result,
// and grants one round-robin writeback per cycle to the scheduler and regfile.
module alu_writeback_arbiter #(
    parameter int DATA_WIDTH                    = 32,
    parameter int NUMBER_OF_FUNCTIONAL_UNITS    = 2,
    parameter int NUMBER_OF_ACTIVE_INSTRUCTIONS = 2,
    parameter int RD_BITS                       = 5,
    parameter int ID_BITS                       = 1,
    parameter int UNIT_BITS                     = 1
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic                                             issue_valid,
    input  logic [UNIT_BITS-1:0]                             issue_unit,
    input  logic [ID_BITS-1:0]                               issue_instruction_id,
    input  logic [RD_BITS-1:0]                               issue_rd,
    input  logic                                             issue_regwrite,
    input  logic [NUMBER_OF_FUNCTIONAL_UNITS-1:0]            fu_done,
    input  logic [NUMBER_OF_FUNCTIONAL_UNITS*DATA_WIDTH-1:0] fu_result,
    output logic [NUMBER_OF_FUNCTIONAL_UNITS-1:0]            unit_ready,
    output logic                                             writeback_valid,
    output logic [ID_BITS-1:0]                               writeback_instruction_id,
    output logic [RD_BITS-1:0]                               writeback_rd,
    output logic [DATA_WIDTH-1:0]                            writeback_data,
    output logic                                             writeback_regwrite,
    output logic                                             issue_error
);

    localparam int N = NUMBER_OF_FUNCTIONAL_UNITS;

    // Catch parameter sets whose index widths cannot address the tables.
    if (ID_BITS < $clog2(NUMBER_OF_ACTIVE_INSTRUCTIONS)) begin : g_bad_id_bits
        $error("ID_BITS too narrow for NUMBER_OF_ACTIVE_INSTRUCTIONS");
    end
    if (UNIT_BITS < $clog2(N)) begin : g_bad_unit_bits
        $error("UNIT_BITS too narrow for NUMBER_OF_FUNCTIONAL_UNITS");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } unit_state_t;

    unit_state_t           r_state      [N];
    unit_state_t           w_state_next [N];

    logic [ID_BITS-1:0]    r_unit_id    [N];
    logic [RD_BITS-1:0]    r_unit_rd    [N];
    logic [DATA_WIDTH-1:0] r_unit_data  [N];
    logic [N-1:0]          r_unit_regwrite;

    logic [UNIT_BITS-1:0]  r_rr_ptr;
    logic [UNIT_BITS-1:0]  w_rr_next;

    logic [N-1:0]          w_issue_sel;
    logic                  w_target_idle;
    logic                  w_issue_accept;
    logic                  w_issue_violation;

    logic [N-1:0]          w_done;
    logic                  w_grant_valid;
    logic [UNIT_BITS-1:0]  w_grant_unit;

    logic                  r_wb_valid;
    logic [ID_BITS-1:0]    r_wb_id;
    logic [RD_BITS-1:0]    r_wb_rd;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_wb_regwrite;
    logic                  r_issue_error;

    // Decode the issue target; an out-of-range unit never matches, so it counts as not idle.
    always_comb begin
        w_issue_sel   = '0;
        w_target_idle = 1'b0;
        for (int u = 0; u < N; u++) begin
            if (issue_unit == UNIT_BITS'(u)) begin
                w_issue_sel[u] = 1'b1;
                w_target_idle  = (r_state[u] == ST_IDLE);
            end
        end
        w_issue_accept    = issue_valid && w_target_idle;
        w_issue_violation = issue_valid && !w_target_idle;
    end

    // Round-robin pick among DONE units, starting the search at r_rr_ptr.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_unit  = '0;
        for (int u = 0; u < N; u++) begin
            w_done[u]     = (r_state[u] == ST_DONE);
            unit_ready[u] = (r_state[u] == ST_IDLE);
        end
        for (int i = 0; i < N; i++) begin
            for (int u = 0; u < N; u++) begin
                if (!w_grant_valid && w_done[u] && (u == ((int'(r_rr_ptr) + i) % N))) begin
                    w_grant_valid = 1'b1;
                    w_grant_unit  = UNIT_BITS'(u);
                end
            end
        end
        w_rr_next = r_rr_ptr;
        if (w_grant_valid) begin
            w_rr_next = (w_grant_unit == UNIT_BITS'(N - 1)) ? '0 : w_grant_unit + UNIT_BITS'(1);
        end
    end

    // Per-unit next state: issue claims an idle unit, fu_done only counts while busy, grant frees it.
    always_comb begin
        for (int u = 0; u < N; u++) begin
            w_state_next[u] = r_state[u];
            case (r_state[u])
                ST_IDLE: if (w_issue_accept && w_issue_sel[u]) w_state_next[u] = ST_BUSY;
                ST_BUSY: if (fu_done[u]) w_state_next[u] = ST_DONE;
                ST_DONE: if (w_grant_valid && (w_grant_unit == UNIT_BITS'(u))) w_state_next[u] = ST_IDLE;
                default: w_state_next[u] = ST_IDLE;
            endcase
        end
    end

    // Unit state register; reset discards any in-flight work.
    always_ff @(posedge clock) begin
        for (int u = 0; u < N; u++) begin
            if (!reset) r_state[u] <= ST_IDLE;
            else        r_state[u] <= w_state_next[u];
        end
    end

    // Per-unit payload capture; only meaningful while the unit is not IDLE, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int u = 0; u < N; u++) begin
            if (w_issue_accept && w_issue_sel[u]) begin
                r_unit_id[u]       <= issue_instruction_id;
                r_unit_rd[u]       <= issue_rd;
                r_unit_regwrite[u] <= issue_regwrite && (issue_rd != '0);
            end
            if ((r_state[u] == ST_BUSY) && fu_done[u]) begin
                r_unit_data[u] <= fu_result[u*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Registered writeback port, round-robin pointer and sticky protocol error.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rr_ptr      <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_id       <= '0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_wb_regwrite <= 1'b0;
            r_issue_error <= 1'b0;
        end else begin
            r_rr_ptr      <= w_rr_next;
            r_wb_valid    <= w_grant_valid;
            r_wb_regwrite <= w_grant_valid && r_unit_regwrite[w_grant_unit];
            if (w_grant_valid) begin
                r_wb_id   <= r_unit_id[w_grant_unit];
                r_wb_rd   <= r_unit_rd[w_grant_unit];
                r_wb_data <= r_unit_data[w_grant_unit];
            end
            if (w_issue_violation) r_issue_error <= 1'b1;
        end
    end

    assign writeback_valid          = r_wb_valid;
    assign writeback_instruction_id = r_wb_id;
    assign writeback_rd             = r_wb_rd;
    assign writeback_data           = r_wb_data;
    assign writeback_regwrite       = r_wb_regwrite;
    assign issue_error              = r_issue_error;

endmodule

// File: tb/tb_alu_writeback_arbiter.sv
// Scoreboard bench for alu_writeback_arbiter: directed stimulus pushes the
// expected writebacks in arbitration order; a negedge monitor pops and compares.
module tb_alu_writeback_arbiter;

    localparam int DW = 32;
    localparam int N  = 2;
    localparam int RB = 5;
    localparam int IB = 1;
    localparam int UB = 1;

    logic            clock;
    logic            reset;
    logic            issue_valid;
    logic [UB-1:0]   issue_unit;
    logic [IB-1:0]   issue_instruction_id;
    logic [RB-1:0]   issue_rd;
    logic            issue_regwrite;
    logic [N-1:0]    fu_done;
    logic [N*DW-1:0] fu_result;
    logic [N-1:0]    unit_ready;
    logic            writeback_valid;
    logic [IB-1:0]   writeback_instruction_id;
    logic [RB-1:0]   writeback_rd;
    logic [DW-1:0]   writeback_data;
    logic            writeback_regwrite;
    logic            issue_error;

    alu_writeback_arbiter #(
        .DATA_WIDTH(DW), .NUMBER_OF_FUNCTIONAL_UNITS(N), .NUMBER_OF_ACTIVE_INSTRUCTIONS(2),
        .RD_BITS(RB), .ID_BITS(IB), .UNIT_BITS(UB)
    ) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_instruction_id(issue_instruction_id), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .fu_done(fu_done), .fu_result(fu_result),
        .unit_ready(unit_ready), .writeback_valid(writeback_valid),
        .writeback_instruction_id(writeback_instruction_id), .writeback_rd(writeback_rd),
        .writeback_data(writeback_data), .writeback_regwrite(writeback_regwrite),
        .issue_error(issue_error)
    );

    typedef struct packed {
        logic [IB-1:0] id;
        logic [RB-1:0] rd;
        logic [DW-1:0] data;
        logic          rw;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int id, input int rd, input logic [DW-1:0] data, input bit rw);
        wb_t e;
        e.id   = IB'(id);
        e.rd   = RB'(rd);
        e.data = data;
        e.rw   = rw;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int unit, input int id, input int rd, input bit rw);
        issue_valid          = 1'b1;
        issue_unit           = UB'(unit);
        issue_instruction_id = IB'(id);
        issue_rd             = RB'(rd);
        issue_regwrite       = rw;
        tick();
        issue_valid          = 1'b0;
    endtask

    task automatic done(input logic [N-1:0] mask, input logic [DW-1:0] r0, input logic [DW-1:0] r1);
        fu_done   = mask;
        fu_result = {r1, r0};
        tick();
        fu_done   = '0;
    endtask

    // Monitor: every writeback pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if (writeback_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got id=%0d rd=%0d data=0x%0h required none",
                         writeback_instruction_id, writeback_rd, writeback_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_id",       64'(writeback_instruction_id), 64'(e.id));
                check("wb_rd",       64'(writeback_rd),             64'(e.rd));
                check("wb_data",     64'(writeback_data),           64'(e.data));
                check("wb_regwrite", 64'(writeback_regwrite),       64'(e.rw));
            end
        end
    end

    initial begin
        reset = 1'b0;
        issue_valid = 1'b0; issue_unit = '0; issue_instruction_id = '0;
        issue_rd = '0; issue_regwrite = 1'b0; fu_done = '0; fu_result = '0;
        tick(); tick();
        check("rst_ready", 64'(unit_ready), 64'h3);
        check("rst_valid", 64'(writeback_valid), 64'h0);
        check("rst_error", 64'(issue_error), 64'h0);
        check("rst_data",  64'(writeback_data), 64'h0);
        reset = 1'b1;

        // Single instruction through unit0.
        issue(0, 0, 5, 1'b1);
        check("t1_ready_busy", 64'(unit_ready), 64'h2);
        tick();
        check("t1_ready_busy2", 64'(unit_ready), 64'h2);
        push(0, 5, 32'hAA, 1'b1);
        done(2'b01, 32'hAA, 32'h0);
        check("t1_ready_done", 64'(unit_ready), 64'h2);
        check("t1_no_wb_yet", 64'(writeback_valid), 64'h0);
        tick();
        check("t1_wb_valid", 64'(writeback_valid), 64'h1);
        check("t1_ready_free", 64'(unit_ready), 64'h3);
        tick();
        check("t1_valid_drop", 64'(writeback_valid), 64'h0);
        check("t1_rw_drop", 64'(writeback_regwrite), 64'h0);
        check("t1_data_hold", 64'(writeback_data), 64'hAA);

        // Simultaneous DONE with rr_ptr = 1 (after the unit0 grant): unit1 first.
        issue(0, 0, 1, 1'b1);
        issue(1, 1, 2, 1'b1);
        push(1, 2, 32'h22, 1'b1);
        push(0, 1, 32'h11, 1'b1);
        done(2'b11, 32'h11, 32'h22);
        tick();
        check("t2a_ready", 64'(unit_ready), 64'h2);
        tick();
        check("t2a_ready2", 64'(unit_ready), 64'h3);

        // Reset to bring rr_ptr to 0; then unit0 wins twice in a row.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        issue(0, 1, 3, 1'b1);
        issue(1, 0, 4, 1'b1);
        push(1, 3, 32'h11, 1'b1);
        push(0, 4, 32'h22, 1'b1);
        done(2'b11, 32'h11, 32'h22);
        tick();
        check("t2b_ready", 64'(unit_ready), 64'h1);
        tick();
        issue(0, 0, 6, 1'b1);
        issue(1, 1, 8, 1'b1);
        push(0, 6, 32'h55, 1'b1);
        push(1, 8, 32'h66, 1'b1);
        done(2'b11, 32'h55, 32'h66);
        tick();
        tick();

        // rd = 0 suppresses the regfile write but still releases the ID.
        issue(1, 1, 0, 1'b1);
        tick();
        push(1, 0, 32'h77, 1'b0);
        done(2'b10, 32'h0, 32'h77);
        tick();
        check("t3_valid", 64'(writeback_valid), 64'h1);
        check("t3_rw", 64'(writeback_regwrite), 64'h0);
        tick();

        // Issue to a busy unit: ignored, sticky error, original instruction intact.
        issue(1, 1, 7, 1'b1);
        check("t4_error_clear", 64'(issue_error), 64'h0);
        issue(1, 0, 9, 1'b0);
        check("t4_error_set", 64'(issue_error), 64'h1);
        check("t4_ready", 64'(unit_ready), 64'h1);
        tick();
        check("t4_error_hold", 64'(issue_error), 64'h1);
        push(1, 7, 32'h88, 1'b1);
        done(2'b10, 32'h0, 32'h88);
        tick();
        check("t4_error_sticky", 64'(issue_error), 64'h1);
        tick();

        // Reset with unit0 BUSY and unit1 DONE: everything dropped.
        issue(0, 0, 10, 1'b1);
        issue(1, 1, 11, 1'b1);
        done(2'b10, 32'h0, 32'h99);
        reset = 1'b0;
        tick();
        check("t5_ready", 64'(unit_ready), 64'h3);
        check("t5_valid", 64'(writeback_valid), 64'h0);
        check("t5_error", 64'(issue_error), 64'h0);
        check("t5_data", 64'(writeback_data), 64'h0);
        check("t5_rd", 64'(writeback_rd), 64'h0);
        reset = 1'b1;
        done(2'b11, 32'hDEAD, 32'hBEEF);
        tick(); tick(); tick();

        // Stray fu_done on an idle unit, and fu_done in the issue cycle: both ignored.
        done(2'b10, 32'h0, 32'hBAD);
        tick();
        check("t6_no_wb", 64'(writeback_valid), 64'h0);
        fu_done   = 2'b01;
        fu_result = {32'h0, 32'hBAD0};
        issue(0, 0, 12, 1'b1);
        fu_done   = '0;
        check("t6_ready_busy", 64'(unit_ready), 64'h2);
        tick(); tick();
        check("t6_still_busy", 64'(unit_ready), 64'h2);
        check("t6_error", 64'(issue_error), 64'h0);
        push(0, 12, 32'hCC, 1'b1);
        done(2'b01, 32'hCC, 32'h0);
        tick();
        check("t6_ready_free", 64'(unit_ready), 64'h3);
        tick(); tick(); tick();

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
